// File: rtl/ps2_rx.sv
// ps2_rx -- PS/2 device-to-host serial receiver.
//
// Two-flop synchronises ps2c/ps2d and glitch-filters ps2c. It then
// deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// Each accepted byte appears on dout together with a one-cycle rx_done_tick.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   : frames with bad parity or a bad stop bit are rejected, and
//               timeouts abort the frame; both pulse frame_err for one cycle.
//   undefined : every completed frame is accepted, and frame_err is tied 0.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ps2c         in   raw PS/2 clock line (async)
//   ps2d         in   raw PS/2 data line (async)
//   rx_en        in   gates the start of new frames only
//   rx_done_tick out  one-cycle strobe, valid byte on dout
//   dout         out  [7:0] last accepted byte, held between frames
//   frame_err    out  one-cycle strobe on a rejected or aborted frame
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 13000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DPS, S_LOAD} state_t;

  logic                  r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk;
  logic                  w_fall;
  state_t                r_state;
  logic [9:0]            r_sr;
  logic [3:0]            r_cnt;
  logic [TW-1:0]         r_tmo;
  logic                  r_done;
  logic [7:0]            r_dout;
`ifdef PS2_PARITY_CHECK_EN
  logic                  r_err;
  logic                  w_frame_ok;
`endif

  // 2-FF synchronisers; the data line is synchronised alongside the clock
  // line so that both see the same delay ahead of the filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2c;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d;
      r_d_s2 <= r_d_s1;
    end
  end

  // The filtered clock changes level only after FILTER_LEN identical samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '1;
      r_fclk <= 1'b1;
    end else begin
      r_filt <= {r_c_s2, r_filt[FILTER_LEN-1:1]};
      if (r_filt == '1)
        r_fclk <= 1'b1;
      else if (r_filt == '0)
        r_fclk <= 1'b0;
    end
  end

  // High in the one cycle before r_fclk drops.
  assign w_fall = r_fclk & (r_filt == '0);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity across data and parity bits, and the stop bit must be 1.
  assign w_frame_ok = (^r_sr[8:0]) & r_sr[9];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
      r_dout  <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_fall && rx_en && !r_d_s2) begin
            r_cnt   <= 4'd9;
            r_tmo   <= '0;
            r_state <= S_DPS;
          end
        end
        S_DPS: begin
          if (w_fall) begin
            r_sr  <= {r_d_s2, r_sr[9:1]};
            r_tmo <= '0;
            if (r_cnt == 4'd0)
              r_state <= S_LOAD;
            else
              r_cnt <= r_cnt - 4'd1;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            // The line went quiet mid-frame: drop the partial byte.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
`ifdef PS2_PARITY_CHECK_EN
            r_err   <= 1'b1;
`endif
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          if (w_frame_ok) begin
            r_dout <= r_sr[7:0];
            r_done <= 1'b1;
          end else begin
            r_err  <= 1'b1;
          end
`else
          r_dout <= r_sr[7:0];
          r_done <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
`ifdef PS2_PARITY_CHECK_EN
  assign frame_err    = r_err;
`else
  assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 400;
  localparam int H  = 30;   // half PS/2 bit period in clk cycles
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ps2c, ps2d, rx_en;
  logic       rx_done_tick, frame_err;
  logic [7:0] dout;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .dout(dout), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tick_cnt = 0, err_cnt = 0;
  logic [7:0] tick_dout = 8'h00;
  logic prev_tick = 1'b0, prev_err = 1'b0;
  logic [7:0] model_dout;

  // Strobe monitor: count events and check one-cycle width and exclusivity.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      tick_cnt  = tick_cnt + 1;
      tick_dout = dout;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_done_tick || frame_err) begin
      checks = checks + 1;
      if ((rx_done_tick && frame_err) || (rx_done_tick && prev_tick) ||
          (frame_err && prev_err)) begin
        errors = errors + 1;
        $display("FAIL strobe_shape tick=%0b err=%0b prev_tick=%0b prev_err=%0b required single exclusive pulses",
                 rx_done_tick, frame_err, prev_tick, prev_err);
      end
    end
    prev_tick = rx_done_tick;
    prev_err  = frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the first nbits bits of an 11-bit frame, device style: data set
  // while the clock is high, clock low for H cycles, then high for H cycles.
  task automatic send_frame(input logic [7:0] d, input bit pinv, input bit stp,
                            input int nbits);
    logic [10:0] f;
    f = {stp, (~^d) ^ pinv, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(H);
      ps2c = 1'b0;
      wait_cyc(H);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         pinv;
    bit         stp;
    bit         en;
    int         nbits;
    int         exp_ticks;
    logic [7:0] exp_dout;
    int         exp_errs;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int t0, e0;
    t0 = tick_cnt;
    e0 = err_cnt;
    rx_en = v.en;
    send_frame(v.data, v.pinv, v.stp, v.nbits);
    wait_cyc(v.nbits == 11 ? 4 * FL : TO + 100);
    chk({v.name, "_ticks"}, tick_cnt - t0, v.exp_ticks);
    chk({v.name, "_dout"}, dout, v.exp_dout);
    chk({v.name, "_errs"}, err_cnt - e0, v.exp_errs);
    if (v.exp_ticks > 0) chk({v.name, "_tick_dout"}, tick_dout, v.exp_dout);
    rx_en = 1'b1;
  endtask

  // Reference: a frame is accepted when it started with rx_en high, all 11
  // bits arrived and (with checking) the ones-count over data+parity is odd
  // and the stop bit is 1. Any other started frame is an error when checking.
  function automatic bit model_accept(input bit en, input bit complete,
                                      input logic [7:0] d, input bit pinv,
                                      input bit stp);
    logic par;
    bit   ok;
    par = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ pinv;
    ok  = (($countones({par, d}) % 2) == 1) && stp;
    return en && complete && (!PCHK || ok);
  endfunction

  vec_t tbl[10];

  initial begin
    logic [7:0] d5;
    d5 = PCHK ? 8'h1C : 8'h23;
    tbl[0] = '{"f1C",     8'h1C, 0, 1, 1, 11, 1, 8'h1C, 0};
    tbl[1] = '{"fF0",     8'hF0, 0, 1, 1, 11, 1, 8'hF0, 0};
    tbl[2] = '{"f1C_b",   8'h1C, 0, 1, 1, 11, 1, 8'h1C, 0};
    tbl[3] = '{"f23",     8'h23, 0, 1, 1, 11, 1, 8'h23, 0};
    tbl[4] = '{"f1C_c",   8'h1C, 0, 1, 1, 11, 1, 8'h1C, 0};
    tbl[5] = '{"f23_par", 8'h23, 1, 1, 1, 11, PCHK ? 0 : 1, d5, PCHK ? 1 : 0};
    tbl[6] = '{"en_off",  8'h55, 0, 1, 0, 11, 0, d5, 0};
    tbl[7] = '{"tmo",     8'h1D, 0, 1, 1, 5,  0, d5, PCHK ? 1 : 0};
    tbl[8] = '{"f1D",     8'h1D, 0, 1, 1, 11, 1, 8'h1D, 0};
    tbl[9] = '{"f76",     8'h76, 0, 1, 1, 11, 1, 8'h76, 0};

    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    wait_cyc(3);
    chk("reset_dout", dout, 8'h00);
    chk("reset_tick", rx_done_tick, 0);
    chk("reset_err", frame_err, 0);
    rst = 1'b0;
    wait_cyc(20);

    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        int t0, e0;
        t0 = tick_cnt; e0 = err_cnt;
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(40);
        chk("glitch_ticks", tick_cnt - t0, 0);
        chk("glitch_errs", err_cnt - e0, 0);
      end
      if (i == 9) begin
        // Abort a frame with reset while the clock line is low.
        send_frame(8'hA5, 0, 1, 6);
        ps2d = 1'b0;
        wait_cyc(H);
        ps2c = 1'b0;
        wait_cyc(FL + 4);
        rst = 1'b1;
        #1;
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_tick", rx_done_tick, 0);
        ps2c = 1'b1; ps2d = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(20);
      end
      run_vec(tbl[i]);
    end

    model_dout = 8'h76;
    for (int k = 0; k < 20; k++) begin
      vec_t v;
      bit acc;
      v.name  = $sformatf("rnd%0d", k);
      v.data  = 8'($urandom);
      v.pinv  = ($urandom % 4) == 0;
      v.stp   = ($urandom % 8) != 0;
      v.en    = ($urandom % 4) != 0;
      v.nbits = (($urandom % 6) == 0) ? 2 + int'($urandom % 9) : 11;
      acc = model_accept(v.en, v.nbits == 11, v.data, v.pinv, v.stp);
      if (acc) model_dout = v.data;
      v.exp_ticks = acc ? 1 : 0;
      v.exp_dout  = model_dout;
      v.exp_errs  = (PCHK && v.en && !acc) ? 1 : 0;
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
